muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit for the execute stage of the pipelined core, parametrised in data width and bits retired per iteration. It accepts one operation from the D-to-E pipeline, computes it over multiple cycles, and presents a held result with a one-cycle done pulse. The hazard unit stalls F/D/E on `busy_o` and kills the operation on a branch flush.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand/result width; must be even.
- `BITS_PER_CYCLE`, 1, quotient/multiplier bits retired per iteration; one of 1, 2, 4; must divide `DATA_WIDTH`.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  launch operation; honoured only when `ready_o`=1.
- `op_i`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a_i`  in  DATA_WIDTH  rs1 operand (forwarded value).
- `b_i`  in  DATA_WIDTH  rs2 operand (forwarded value).
- `flush_i`  in  1  abort the in-flight operation.
- `ready_o`  out  1  can accept `start_i` this cycle.
- `busy_o`  out  1  operation in flight; drives the pipeline stall.
- `done_o`  out  1  one-cycle pulse; `result_o` valid.
- `result_o`  out  DATA_WIDTH  result; held until the next accepted start.

## Operation
- FSM states: IDLE, CALC, FIXUP, DONE.
- IDLE + `start_i`:
  - Latch `op_i`, `a_i`, `b_i`.
  - Special case (division by zero, or signed overflow 0x80..0 / -1): go to DONE.
  - Otherwise: convert signed operands to magnitudes, record the result sign, clear the iteration counter, go to CALC.
- CALC:
  - Multiply: shift-add, `BITS_PER_CYCLE` multiplier bits per cycle, into a 2×DATA_WIDTH accumulator.
  - Divide: restoring division, `BITS_PER_CYCLE` quotient bits per cycle.
  - The counter runs 0..N-1, where N = DATA_WIDTH/BITS_PER_CYCLE. Go to FIXUP when the counter reaches N-1.
- FIXUP:
  - Apply sign correction.
  - Quotient sign = sign(a) XOR sign(b). Remainder takes the sign of a.
  - MULHSU treats a as signed and b as unsigned.
  - Select the low half (MUL) or high half (MULH*).
  - Load `result_o`; go to DONE.
- DONE: `done_o`=1 for this one cycle, then go to IDLE. A `start_i` in DONE is accepted, giving back-to-back operation with no IDLE bubble.
- Special-case results:
  - Divide by zero: DIV/DIVU = all ones; REM/REMU = a.
  - Signed overflow: DIV = a; REM = 0.
- `flush_i` in any state: go to IDLE next edge; `done_o` is not raised for the aborted operation; `result_o` is unchanged.
- `flush_i` and `start_i` in the same cycle: flush wins and the start is dropped.
- `ready_o` = state is IDLE or DONE. `busy_o` = state is CALC or FIXUP, or (`start_i` accepted and not special-case), combinationally, so the stall asserts in the accept cycle.
- Arithmetic is modulo 2^DATA_WIDTH for outputs. Internal accumulator is 2×DATA_WIDTH+1 bits for the divide subtract.

## Timing
- Reset (async assert, sync release): state IDLE, `result_o`=0, `done_o`=0, `busy_o`=0, `ready_o`=1, counter 0.
- Normal latency: start sampled at edge 0 → CALC for edges 1..N → FIXUP after edge N+1 → `done_o` high during the cycle after edge N+2.
  - DATA_WIDTH=32, BITS_PER_CYCLE=1: done after 34 cycles.
  - DATA_WIDTH=32, BITS_PER_CYCLE=4: done after 10 cycles.
- Special-case latency: `done_o` high in the cycle after edge 1.
- `result_o` changes only on the edge entering DONE.
- Reset mid-operation: immediate return to the reset values; no `done_o`.

## Structure
- `muldiv_pkg`: `muldiv_op_e` (8 funct3 codes), `muldiv_state_e`, helper functions `is_div(op)`, `is_signed_a(op)`, `is_signed_b(op)`.
- Sub-module `muldiv_step`: purely combinational. Performs one `BITS_PER_CYCLE` iteration (shift-add or restoring-subtract) on {accumulator, operand} → next {accumulator, operand}. It is instantiated once in `muldiv_unit`; sign handling and the FSM live in `muldiv_unit`.

## Test plan
- MUL a=7, b=0xFFFFFFFD → `result_o`=0xFFFFFFEB; `done_o` at cycle 34 (BITS_PER_CYCLE=1) and at cycle 10 (BITS_PER_CYCLE=4); `busy_o` high cycles 0–33.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0. Each has `done_o` one cycle after start and `busy_o` never high.
- Start DIVU, assert `flush_i` at cycle 10 → IDLE at cycle 11, no `done_o`, `result_o` keeps the previous value. Same-cycle start+flush → no operation launched.
- Back-to-back start in the DONE cycle → second result correct and no bubble. Deassert `rst_n_i` mid-CALC → outputs return to reset values immediately, and the next start completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types and decode helpers for the iterative RV32M
//               multiply/divide unit.
//               - muldiv_op_e    : funct3 operation codes
//               - muldiv_state_e : sequencer states
//               - is_div / is_rem / is_signed_a / is_signed_b : op decode
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } muldiv_state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    // MUL only uses the low half, which is sign-agnostic, so it is
    // treated as unsigned.
    function automatic logic is_signed_a(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : Combinational datapath for one iteration of the multiply/
//               divide unit, retiring BITS_PER_CYCLE bits.
//               Multiply : shift-add, multiplier in acc[W-1:0], partial
//                          product in acc[2W-1:W], LSB first.
//               Divide   : restoring, remainder in acc[2W:W], dividend
//                          shifted out of / quotient shifted into acc[W-1:0].
// Ports       : is_div_i   - select divide (1) or multiply (0) iteration
//               acc_i      - current accumulator (2W+1 bits)
//               operand_i  - multiplicand or divisor magnitude
//               acc_o      - accumulator after BITS_PER_CYCLE iterations
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                    is_div_i,
    input  logic [2*DATA_WIDTH:0]   acc_i,
    input  logic [DATA_WIDTH-1:0]   operand_i,
    output logic [2*DATA_WIDTH:0]   acc_o
);

    localparam int W = DATA_WIDTH;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_iter
        logic [2*W:0] acc_in;
        logic [2*W:0] acc_nxt;
        logic [W:0]   mul_sum;
        logic [W:0]   rem_sh;
        logic [W:0]   diff;
        logic         fits;
        logic         unused_top;

        if (g == 0) begin : g_first
            assign acc_in = acc_i;
        end else begin : g_chain
            assign acc_in = g_iter[g-1].acc_nxt;
        end

        // Top bit is always zero on entry: the product fits in 2W bits and
        // the remainder is below the divisor before each shift.
        assign unused_top = acc_in[2*W];

        assign mul_sum = {1'b0, acc_in[2*W-1:W]} +
                         (acc_in[0] ? {1'b0, operand_i} : {(W+1){1'b0}});

        assign rem_sh  = acc_in[2*W-1:W-1];
        assign diff    = rem_sh - {1'b0, operand_i};
        assign fits    = ~diff[W];

        assign acc_nxt = is_div_i
                       ? {(fits ? diff : rem_sh), acc_in[W-2:0], fits}
                       : {1'b0, mul_sum, acc_in[W-1:1]};
    end

    assign acc_o = g_iter[BITS_PER_CYCLE-1].acc_nxt;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit for the execute stage.
//               DATA_WIDTH must be even; BITS_PER_CYCLE is 1, 2 or 4 and
//               must divide DATA_WIDTH.
// Ports       : clk_i     - clock, rising edge
//               rst_n_i   - asynchronous active-low reset
//               start_i   - launch op (honoured when ready_o)
//               op_i      - funct3 operation code
//               a_i, b_i  - rs1 / rs2 operands
//               flush_i   - abort in-flight op, drop same-cycle start
//               ready_o   - can accept start_i this cycle
//               busy_o    - pipeline stall request
//               done_o    - one-cycle completion pulse
//               result_o  - result, held between completions
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  flush_i,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int W     = DATA_WIDTH;
    localparam int N     = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    muldiv_state_e    state_q,   state_d;
    muldiv_op_e       op_q,      op_d;
    logic [W-1:0]     operand_q, operand_d;
    logic [W-1:0]     result_q,  result_d;
    logic [2*W:0]     acc_q,     acc_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             neg_q,     neg_d;

    muldiv_op_e       op_in;
    logic [2*W:0]     acc_step;
    logic             accept, special, div_by_zero, overflow;
    logic             sign_a, sign_b;
    logic [W-1:0]     mag_a, mag_b, special_res;
    logic [2*W-1:0]   prod_s;
    logic [W-1:0]     div_sel, div_res, fix_res;

    assign op_in    = muldiv_op_e'(op_i);
    assign ready_o  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept   = start_i && ready_o && !flush_i;
    assign done_o   = (state_q == ST_DONE);
    assign busy_o   = (state_q == ST_CALC) || (state_q == ST_FIXUP) ||
                      (accept && !special);
    assign result_o = result_q;

    muldiv_step #(
        .DATA_WIDTH     (DATA_WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .is_div_i  (is_div(op_q)),
        .acc_i     (acc_q),
        .operand_i (operand_q),
        .acc_o     (acc_step)
    );

    // Operand decode at accept time: magnitudes and special cases.
    always_comb begin
        sign_a      = is_signed_a(op_in) && a_i[W-1];
        sign_b      = is_signed_b(op_in) && b_i[W-1];
        mag_a       = sign_a ? -a_i : a_i;
        mag_b       = sign_b ? -b_i : b_i;
        div_by_zero = is_div(op_in) && (b_i == '0);
        overflow    = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                      (a_i == {1'b1, {(W-1){1'b0}}}) && (b_i == '1);
        special     = div_by_zero || overflow;
        if (div_by_zero) begin
            special_res = is_rem(op_in) ? a_i : '1;
        end else begin
            special_res = is_rem(op_in) ? '0 : a_i;
        end
    end

    // Sign correction and half/part selection once iterations are complete.
    always_comb begin
        prod_s  = neg_q ? -acc_q[2*W-1:0] : acc_q[2*W-1:0];
        div_sel = is_rem(op_q) ? acc_q[2*W-1:W] : acc_q[W-1:0];
        div_res = neg_q ? -div_sel : div_sel;
        if (is_div(op_q)) begin
            fix_res = div_res;
        end else if (op_q == OP_MUL) begin
            fix_res = prod_s[W-1:0];
        end else begin
            fix_res = prod_s[2*W-1:W];
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        operand_d = operand_q;
        result_d  = result_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    op_d = op_in;
                    if (special) begin
                        result_d = special_res;
                        state_d  = ST_DONE;
                    end else begin
                        // Dividend / multiplier starts in the low half.
                        acc_d     = {{(W+1){1'b0}}, mag_a};
                        operand_d = mag_b;
                        cnt_d     = '0;
                        // Remainder follows the dividend sign only.
                        neg_d     = is_rem(op_in) ? sign_a : (sign_a ^ sign_b);
                        state_d   = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                result_d = fix_res;
                state_d  = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush aborts without touching the visible result.
        if (flush_i) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MUL;
            operand_q <= '0;
            result_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            operand_q <= operand_d;
            result_q  <= result_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit. Two instances
//               (1 and 4 bits per cycle) share stimulus; outputs of the
//               instance under test are selected by sel4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, start, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        ready1, busy1, done1, ready4, busy4, done4;
    logic [31:0] res1, res4;
    logic        sel4;
    logic        ready_w, busy_w, done_w;
    logic [31:0] res_w;

    int          checks = 0;
    int          errors = 0;
    int          busy_cnt;
    int          done_cnt;
    logic [31:0] last_exp;

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op),
        .a_i(a), .b_i(b), .flush_i(flush), .ready_o(ready1),
        .busy_o(busy1), .done_o(done1), .result_o(res1)
    );

    muldiv_unit #(.DATA_WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op),
        .a_i(a), .b_i(b), .flush_i(flush), .ready_o(ready4),
        .busy_o(busy4), .done_o(done4), .result_o(res4)
    );

    assign ready_w = sel4 ? ready4 : ready1;
    assign busy_w  = sel4 ? busy4  : busy1;
    assign done_w  = sel4 ? done4  : done1;
    assign res_w   = sel4 ? res4   : res1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int norm_lat();
        return sel4 ? 10 : 34;
    endfunction

    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        #1;
        busy_cnt = busy_w ? 1 : 0;
    endtask

    task automatic wait_done(input string tag, input logic [31:0] exp,
                             input int exp_lat, input int exp_busy);
        int   cyc  = 0;
        logic seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            cyc++;
            if (done_w) seen = 1'b1;
            else if (busy_w) busy_cnt++;
        end
        check({tag, " done seen"},   32'(seen),     32'd1);
        check({tag, " latency"},     32'(cyc),      32'(exp_lat));
        check({tag, " result"},      res_w,         exp);
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_busy));
        last_exp = exp;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input logic spec);
        launch(o, x, y);
        wait_done(tag, exp, spec ? 1 : norm_lat(), spec ? 0 : norm_lat());
        @(negedge clk);
        #1;
        check({tag, " done pulse"}, 32'(done_w), 32'd0);
    endtask

    task automatic count_done(input int n);
        done_cnt = 0;
        repeat (n) begin
            @(negedge clk);
            #1;
            if (done_w) done_cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b000;
        a = '0; b = '0; sel4 = 1'b0; last_exp = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset result", res_w, 32'h0);
        check("reset done",   32'(done_w),  32'd0);
        check("reset busy",   32'(busy_w),  32'd0);
        check("reset ready",  32'(ready_w), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("MUL",    OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
        run_op("MULH",   OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
        run_op("MULHU",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run_op("MULHSU", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op("DIV",    OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
        run_op("REM",    OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
        run_op("DIVU big", OP_DIVU, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 1'b0);
        run_op("DIV neg b", OP_DIV, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0);
        run_op("REM neg b", OP_REM, 32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0);

        // Back-to-back: second start issued in the DONE cycle of the first.
        launch(OP_DIVU, 32'd100, 32'd7);
        wait_done("DIVU b2b1", 32'd14, 34, 34);
        launch(OP_REMU, 32'd100, 32'd7);
        check("b2b accept busy", 32'(busy_w), 32'd1);
        wait_done("REMU b2b2", 32'd2, 34, 34);
        @(negedge clk);
        #1;

        run_op("DIV by 0",  OP_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 1'b1);
        run_op("REMU by 0", OP_REMU, 32'd5,        32'd0,        32'd5,        1'b1);
        run_op("DIV ovf",   OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        run_op("REM ovf",   OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1);

        // Flush in cycle 10 of a DIVU.
        launch(OP_DIVU, 32'd1000, 32'd3);
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush ready",  32'(ready_w), 32'd1);
        check("flush busy",   32'(busy_w),  32'd0);
        check("flush result", res_w,        last_exp);
        count_done(40);
        check("flush no done", 32'(done_cnt), 32'd0);

        // Start and flush together: start dropped.
        start = 1'b1; flush = 1'b1; op = OP_DIV; a = 32'd9; b = 32'd3;
        #1;
        check("start+flush busy", 32'(busy_w), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        check("start+flush ready", 32'(ready_w), 32'd1);
        count_done(40);
        check("start+flush no done", 32'(done_cnt), 32'd0);
        check("start+flush result",  res_w,         last_exp);

        // Asynchronous reset mid-CALC.
        launch(OP_MUL, 32'd3, 32'd5);
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst result", res_w,        32'h0);
        check("midrst busy",   32'(busy_w),  32'd0);
        check("midrst ready",  32'(ready_w), 32'd1);
        check("midrst done",   32'(done_w),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("MUL after rst", OP_MUL, 32'd3, 32'd5, 32'd15, 1'b0);

        // Four bits per iteration.
        sel4 = 1'b1;
        @(negedge clk);
        run_op("x4 MUL",   OP_MUL,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
        run_op("x4 DIV",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
        run_op("x4 MULHU", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run_op("x4 REMU",  OP_REMU,  32'd100,      32'd7,        32'd2,        1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
